// File: rtl/sm_integrator_5bit.sv
// Integrate-and-dump of 5-bit sign-magnitude samples, saturating to +/-31.
// Define SM_INTEG_STICKY_EN to make sat_out sticky until clear/reset.
module sm_integrator_5bit #(
  parameter int DUMP_LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       sign_in,
  input  logic [4:0] mag_in,
  output logic       out_valid,
  output logic       sign_out,
  output logic [4:0] mag_out,
  output logic       sat_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DUMP
  } state_t;

  localparam logic [5:0] LAST = 6'(DUMP_LEN - 1);

  state_t            state_q, state_d;
  logic signed [6:0] acc_q;
  logic [5:0]        cnt_q;
  logic              wsat_q;

  logic [6:0]        mag_ext;
  logic signed [6:0] smp;
  logic signed [7:0] sum;
  logic signed [6:0] res;
  logic              step_sat;
  logic              res_neg;
  logic [4:0]        res_mag;
  logic              accept;
  logic              last;

  assign mag_ext = {2'b00, mag_in};
  assign smp     = sign_in ? $signed(-mag_ext) : $signed(mag_ext);
  assign sum     = {acc_q[6], acc_q} + {smp[6], smp};

  always_comb begin
    res      = sum[6:0];
    step_sat = 1'b0;
    unique case (1'b1)
      (sum > 8'sd31): begin
        res      = 7'sd31;
        step_sat = 1'b1;
      end
      (sum < -8'sd31): begin
        res      = -7'sd31;
        step_sat = 1'b1;
      end
      default: ;
    endcase
  end

  // -0 collapses to +0 here because res is two's complement
  assign res_neg = res[6];
  assign res_mag = res_neg ? 5'(-res) : res[4:0];

  assign in_ready  = (state_q == ACCUM) && en;
  assign out_valid = (state_q == DUMP);
  assign accept    = in_ready && in_valid && !clear;
  assign last      = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (en) state_d = ACCUM;
        ACCUM: begin
          if (!en)                state_d = IDLE;
          else if (accept && last) state_d = DUMP;
        end
        DUMP:    state_d = en ? ACCUM : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wsat_q   <= 1'b0;
      sign_out <= 1'b0;
      mag_out  <= '0;
      sat_out  <= 1'b0;
    end else if (clear) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      wsat_q   <= 1'b0;
      sign_out <= 1'b0;
      mag_out  <= '0;
      sat_out  <= 1'b0;
    end else if (!in_ready) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      wsat_q <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc_q    <= '0;
        cnt_q    <= '0;
        wsat_q   <= 1'b0;
        sign_out <= res_neg;
        mag_out  <= res_mag;
`ifdef SM_INTEG_STICKY_EN
        sat_out  <= sat_out | wsat_q | step_sat;
`else
        sat_out  <= wsat_q | step_sat;
`endif
      end else begin
        acc_q  <= res;
        cnt_q  <= cnt_q + 6'd1;
        wsat_q <= wsat_q | step_sat;
      end
    end
  end

endmodule

// File: tb/tb_sm_integrator_5bit.sv
// Directed bench for sm_integrator_5bit with DUMP_LEN=4.
// Expected sat_out follows SM_INTEG_STICKY_EN when defined.
module tb_sm_integrator_5bit;

`ifdef SM_INTEG_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic       sign_in;
  logic [4:0] mag_in;
  logic       out_valid;
  logic       sign_out;
  logic [4:0] mag_out;
  logic       sat_out;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses = 0;

  sm_integrator_5bit #(.DUMP_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .mag_in    (mag_in),
    .out_valid (out_valid),
    .sign_out  (sign_out),
    .mag_out   (mag_out),
    .sat_out   (sat_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (out_valid) pulses <= pulses + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send(input logic s, input logic [4:0] m);
    int n;
    n = 0;
    sign_in  = s;
    mag_in   = m;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic window(input string tag, input logic [3:0] s,
                        input logic [4:0] m0, input logic [4:0] m1,
                        input logic [4:0] m2, input logic [4:0] m3,
                        input logic es, input logic [4:0] em,
                        input logic et);
    int p0;
    p0 = pulses;
    send(s[0], m0);
    send(s[1], m1);
    send(s[2], m2);
    send(s[3], m3);
    check({tag, ".ov"},   int'(out_valid), 1);
    check({tag, ".rdy"},  int'(in_ready), 0);
    check({tag, ".sign"}, int'(sign_out), int'(es));
    check({tag, ".mag"},  int'(mag_out), int'(em));
    check({tag, ".sat"},  int'(sat_out), int'(et));
    @(posedge clk); #1;
    check({tag, ".pulses"}, pulses - p0, 1);
    check({tag, ".ov_lo"}, int'(out_valid), 0);
  endtask

  initial begin
    int p0;
    rst_n    = 1'b0;
    en       = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b1;
    sign_in  = 1'b0;
    mag_in   = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst.rdy",  int'(in_ready), 0);
    check("rst.ov",   int'(out_valid), 0);
    check("rst.sign", int'(sign_out), 0);
    check("rst.mag",  int'(mag_out), 0);
    check("rst.sat",  int'(sat_out), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    window("w1", 4'b1010, 5'd5, 5'd3, 5'd7, 5'd2, 1'b0, 5'd7, 1'b0);
    window("w2", 4'b0100, 5'd20, 5'd20, 5'd5, 5'd1, 1'b0, 5'd27, 1'b1);
    window("w3", 4'b1011, 5'd0, 5'd10, 5'd3, 5'd0, 1'b1, 5'd7, STICKY);
    window("w4", 4'b1111, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, STICKY);
    window("wn", 4'b0011, 5'd20, 5'd20, 5'd0, 5'd0, 1'b1, 5'd31, 1'b1);

    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr.sign", int'(sign_out), 0);
    check("clr.mag",  int'(mag_out), 0);
    check("clr.sat",  int'(sat_out), 0);
    check("clr.rdy",  int'(in_ready), 0);

    window("w5", 4'b0000, 5'd2, 5'd2, 5'd2, 5'd2, 1'b0, 5'd8, 1'b0);

    p0 = pulses;
    send(1'b0, 5'd9);
    send(1'b0, 5'd9);
    en = 1'b0;
    #1;
    check("endrop.rdy", int'(in_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    check("endrop.pulses", pulses - p0, 0);
    check("endrop.mag", int'(mag_out), 8);
    en = 1'b1;
    window("w6", 4'b0000, 5'd1, 5'd1, 5'd1, 5'd1, 1'b0, 5'd4, 1'b0);

    p0 = pulses;
    send(1'b0, 5'd1);
    send(1'b0, 5'd1);
    send(1'b0, 5'd1);
    en       = 1'b0;
    in_valid = 1'b1;
    #1;
    check("enlast.rdy", int'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("enlast.pulses", pulses - p0, 0);
    en = 1'b1;
    window("w7", 4'b0000, 5'd3, 5'd3, 5'd3, 5'd3, 1'b0, 5'd12, 1'b0);

    send(1'b0, 5'd9);
    send(1'b0, 5'd9);
    rst_n = 1'b0;
    #1;
    check("mrst.mag",  int'(mag_out), 0);
    check("mrst.rdy",  int'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    window("w8", 4'b1111, 5'd1, 5'd1, 5'd1, 5'd1, 1'b1, 5'd4, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_integrator_5bit.md
# sm_integrator_5bit

Integrate-and-dump accumulator for 5-bit sign-magnitude samples, the consumer side of the loop-filter adder/subtractor format (sign bit plus 5-bit magnitude). Accepts a stream of signed phase-error samples under a valid/ready handshake and sums them with saturation to ±31. After every DUMP_LEN accepted samples it emits the window sum in sign-magnitude form for the DCO control word path.

## Interface
- DUMP_LEN, 8: accepted samples per integration window; legal 1..32
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- en  input  1  integrator enable; low forces IDLE
- clear  input  1  synchronous clear, highest priority after reset
- in_valid  input  1  sample present
- in_ready  output  1  sample accepted when in_valid && in_ready
- sign_in  input  1  sample sign, 1 = negative
- mag_in  input  5  sample magnitude
- out_valid  output  1  one-cycle pulse: new window result
- sign_out  output  1  result sign, 1 = negative
- mag_out  output  5  result magnitude
- sat_out  output  1  saturation indicator

## Operation
- Sample value: sign_in ? -mag_in : +mag_in; sign_in=1 with mag_in=0 is zero.
- Internal accumulator acc: signed, minimum 7 bits; per accepted sample, acc_next = clamp(acc + sample, -31, +31). Any step where the clamp engages sets the window saturation flag wsat.
- Sample counter cnt: 0..DUMP_LEN-1, increments per accepted sample.
- FSM states:
  - IDLE: in_ready=0, acc=0, cnt=0, wsat=0. en=1 -> ACCUM.
  - ACCUM: in_ready=1. Accepted sample with cnt==DUMP_LEN-1 -> DUMP; result registers load clamp(acc+sample), acc, cnt, wsat cleared on the same edge. en=0 -> IDLE, window abandoned, no dump, result outputs hold.
  - DUMP: one cycle; in_ready=0, out_valid=1. Next: ACCUM if en=1, else IDLE.
- Result conversion: sign_out = (result < 0); mag_out = |result|. Zero result always gives sign_out=0 (no negative zero).
- sign_out, mag_out, sat_out hold between dumps.
- clear=1: state -> IDLE, acc, cnt, wsat, sign_out, mag_out, sat_out, out_valid all 0; clear overrides en and in_valid that cycle.
- en and a final sample in the same cycle as en falling: en=0 wins, sample not accepted (in_ready already high, so in_ready is defined as state==ACCUM && en).

## Timing
- Reset values: in_ready=0, out_valid=0, sign_out=0, mag_out=0, sat_out=0; state IDLE.
- en high -> ACCUM after one edge; in_ready high the following cycle.
- Latency: out_valid asserted in the cycle after the edge accepting the last window sample; result outputs valid in that same cycle.
- Throughput: DUMP_LEN samples per DUMP_LEN+1 cycles maximum (one bubble in DUMP).
- DUMP_LEN=1: every accepted sample produces a dump; ACCUM and DUMP alternate.
- Reset asserted mid-window: all state dropped immediately, no partial dump.

## Configuration
- SM_INTEG_STICKY_EN defined: sat_out is sticky; at each dump sat_out <= sat_out | wsat; cleared only by clear or rst_n.
- Not defined: at each dump sat_out <= wsat (reflects the most recent window only).

## Test plan
- Reset: rst_n low with en=1, in_valid=1 -> in_ready=0, out_valid=0, sign_out=0, mag_out=0, sat_out=0.
- DUMP_LEN=4, samples +5, -3, +7, -2 back-to-back -> single out_valid pulse, sign_out=0, mag_out=7, sat_out=0, in_ready low in DUMP cycle.
- DUMP_LEN=4, samples +20, +20, -5, +1 -> clamp at 31 then 26, 27; out sign_out=0, mag_out=27, sat_out=1.
- DUMP_LEN=4, samples -0, -10, +3, -0 -> sign_out=1, mag_out=7; single window of all -0 -> sign_out=0, mag_out=0.
- en dropped after 2 of 4 samples -> no out_valid, outputs hold prior values; re-enable plus +1,+1,+1,+1 -> mag_out=4 (no carry-over from abandoned window).
- Saturating window followed by clean window: with SM_INTEG_STICKY_EN sat_out stays 1 until clear; without it sat_out returns to 0 at second dump.
